// File: rtl/led_inv_mix_columns.sv
// Iterative LED MixColumnsSerial for decryption: applies A^-1 four times, all columns in parallel.
// Optional macro LED_INV_MC_FWD_EN adds a mode input selecting the forward step A instead.
module led_inv_mix_columns (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:63] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:63] out_data,
    output logic        busy
`ifdef LED_INV_MC_FWD_EN
    ,
    input  logic        mode
`endif
);

    // state | meaning
    // IDLE  | waiting for a state to accept, in_ready high
    // RUN   | one matrix step per cycle, cnt counts 0..3
    // DONE  | result held on out_data until out_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  cnt;
    logic [0:63] work;
    logic [0:63] step_nxt;
    logic        load;
    logic        step;

    // GF(2^4) multiply by x, reduction polynomial x^4+x+1
    function automatic logic [3:0] xt(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
    endfunction

    function automatic logic [3:0] mul_d(input logic [3:0] v);
        return xt(xt(xt(v))) ^ xt(xt(v)) ^ v;
    endfunction

    // Nibble k sits at bits [4k : 4k+3]; slicing into [3:0] keeps bit 4k as the MSB.
    function automatic logic [0:63] inv_step(input logic [0:63] s);
        logic [0:63] r;
        logic [3:0]  y0, y1, y2, y3;
        r = s;
        for (int c = 0; c < 4; c++) begin
            y0 = s[4*c      +: 4];
            y1 = s[4*(4+c)  +: 4];
            y2 = s[4*(8+c)  +: 4];
            y3 = s[4*(12+c) +: 4];
            r[4*c      +: 4] = mul_d(y0 ^ xt(y1) ^ xt(y2) ^ y3);
            r[4*(4+c)  +: 4] = y0;
            r[4*(8+c)  +: 4] = y1;
            r[4*(12+c) +: 4] = y2;
        end
        return r;
    endfunction

`ifdef LED_INV_MC_FWD_EN
    logic mode_q;

    function automatic logic [0:63] fwd_step(input logic [0:63] s);
        logic [0:63] r;
        logic [3:0]  x0, x1, x2, x3;
        r = s;
        for (int c = 0; c < 4; c++) begin
            x0 = s[4*c      +: 4];
            x1 = s[4*(4+c)  +: 4];
            x2 = s[4*(8+c)  +: 4];
            x3 = s[4*(12+c) +: 4];
            r[4*c      +: 4] = x1;
            r[4*(4+c)  +: 4] = x2;
            r[4*(8+c)  +: 4] = x3;
            r[4*(12+c) +: 4] = xt(xt(x0)) ^ x1 ^ xt(x2) ^ xt(x3);
        end
        return r;
    endfunction

    always_comb begin
        step_nxt = mode_q ? fwd_step(work) : inv_step(work);
    end
`else
    always_comb begin
        step_nxt = inv_step(work);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == 2'd3) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 2'd0;
            work <= '0;
`ifdef LED_INV_MC_FWD_EN
            mode_q <= 1'b0;
`endif
        end else if (load) begin
            cnt  <= 2'd0;
            work <= in_data;
`ifdef LED_INV_MC_FWD_EN
            mode_q <= mode;
`endif
        end else if (step) begin
            cnt  <= cnt + 2'd1;
            work <= step_nxt;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = work;

endmodule

// File: tb/tb_led_inv_mix_columns.sv
// Self-checking bench for led_inv_mix_columns: directed vectors, randomized states, backpressure, reset.
module tb_led_inv_mix_columns;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;
`ifdef LED_INV_MC_FWD_EN
    logic        mode;
`endif

    int errors = 0;
    int checks = 0;

    led_inv_mix_columns dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef LED_INV_MC_FWD_EN
        ,
        .mode      (mode)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Generic shift-and-add multiply in GF(2^4) mod x^4+x+1.
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        logic [3:0] bb;
        p  = 4'h0;
        aa = a;
        bb = b;
        for (int i = 0; i < 4; i++) begin
            if (bb[0]) p = p ^ aa;
            bb = bb >> 1;
            aa = aa[3] ? ((aa << 1) ^ 4'h3) : (aa << 1);
        end
        return p;
    endfunction

    // Nibble k is d[63-4k -: 4]; column c holds nibbles c, c+4, c+8, c+12.
    function automatic logic [63:0] ref_mc(input logic [63:0] d, input bit fwd);
        logic [3:0]  n [16];
        logic [3:0]  col [4];
        logic [3:0]  nc [4];
        logic [63:0] r;
        for (int k = 0; k < 16; k++) n[k] = d[63-4*k -: 4];
        for (int c = 0; c < 4; c++) begin
            for (int r_ = 0; r_ < 4; r_++) col[r_] = n[4*r_ + c];
            for (int s = 0; s < 4; s++) begin
                if (fwd) begin
                    nc[0] = col[1];
                    nc[1] = col[2];
                    nc[2] = col[3];
                    nc[3] = gf_mul(4'h4, col[0]) ^ col[1] ^ gf_mul(4'h2, col[2]) ^ gf_mul(4'h2, col[3]);
                end else begin
                    nc[0] = gf_mul(4'hD, col[0] ^ gf_mul(4'h2, col[1]) ^ gf_mul(4'h2, col[2]) ^ col[3]);
                    nc[1] = col[0];
                    nc[2] = col[1];
                    nc[3] = col[2];
                end
                col = nc;
            end
            for (int r_ = 0; r_ < 4; r_++) n[4*r_ + c] = col[r_];
        end
        r = '0;
        for (int k = 0; k < 16; k++) r[63-4*k -: 4] = n[k];
        return r;
    endfunction

    // Called on a negedge in IDLE; returns on the negedge after the result appears
    // (or after release back to IDLE when rel is set).
    task automatic do_op(input logic [63:0] d, input bit fwd, input logic [63:0] exp, input bit rel);
        in_valid = 1'b1;
        in_data  = d;
`ifdef LED_INV_MC_FWD_EN
        mode     = fwd;
`endif
        @(negedge clk);
        in_valid = 1'b0;
        chk("accept_busy", {63'd0, busy}, 64'd1);
        chk("accept_in_ready", {63'd0, in_ready}, 64'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("latency_out_valid", {63'd0, out_valid}, (k == 4) ? 64'd1 : 64'd0);
        end
        chk("result", out_data, exp);
        if (rel) begin
            out_ready = 1'b1;
            @(negedge clk);
            chk("release_in_ready", {63'd0, in_ready}, 64'd1);
            chk("release_out_valid", {63'd0, out_valid}, 64'd0);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        logic [63:0] d;
        logic [63:0] held;
        bit          fwd;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef LED_INV_MC_FWD_EN
        mode      = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_out_data", out_data, 64'd0);

        rst_n = 1'b1;
        do_op(64'h4000_8000_B000_2000, 1'b0, 64'h1000_0000_0000_0000, 1'b1);
        do_op(64'h4444_8888_BBBB_2222, 1'b0, 64'h1111_0000_0000_0000, 1'b1);
        do_op(64'h0, 1'b0, 64'h0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            d = {$urandom, $urandom};
            do_op(d, 1'b0, ref_mc(d, 1'b0), 1'b1);
        end

        // Backpressure: result must hold while inputs wiggle.
        d    = {$urandom, $urandom};
        held = ref_mc(d, 1'b0);
        do_op(d, 1'b0, held, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'($urandom);
            in_data   = {$urandom, $urandom};
            out_ready = 1'b0;
            @(negedge clk);
            chk("stall_out_data", out_data, held);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
        end
        in_valid  = 1'b1;
        in_data   = {$urandom, $urandom};
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_in_ready", {63'd0, in_ready}, 64'd1);
        chk("stall_release_busy", {63'd0, busy}, 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset while in RUN with cnt == 2.
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom};
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midreset_out_data", out_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d = {$urandom, $urandom};
        do_op(d, 1'b0, ref_mc(d, 1'b0), 1'b1);

`ifdef LED_INV_MC_FWD_EN
        do_op(64'h1000_0000_0000_0000, 1'b1, 64'h4000_8000_B000_2000, 1'b1);
        do_op(64'h4000_8000_B000_2000, 1'b0, 64'h1000_0000_0000_0000, 1'b1);
        for (int i = 0; i < 6; i++) begin
            d   = {$urandom, $urandom};
            fwd = 1'($urandom);
            do_op(d, fwd, ref_mc(d, fwd), 1'b1);
        end
`endif

        // Random round trip with model-only expectations and immediate release.
        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom};
            do_op(d, 1'b0, ref_mc(d, 1'b0), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
